bus_arbiter8: RTL and testbench
===============================

BUS_ARBITER8 -- requirements
Module: bus_arbiter8

Interface
REQ-001 The module SHALL have parameter MAX_HOLD, default 15, range 1..15: the maximum number of grant cycles an owner keeps the bus while another requester is pending.
REQ-002 CLK  input  1  is the single clock; all state updates SHALL occur on its rising edge.
REQ-003 RST  input  1  is the reset: asynchronous, active-high.
REQ-004 REQ  input  8  carries the per-requester bus request; bit i is requester i, and the request is held high for as long as the bus is wanted.
REQ-005 SEL  output  3  carries the index of the current owner, registered.
REQ-006 EN  output  1  indicates that the bus grant is valid, registered.
REQ-007 GNT  output  8  carries the one-hot grant: a decode of SEL when EN=1, otherwise all zeros.
REQ-008 BUSY  output  1  SHALL be high whenever the state is not IDLE.

Function
REQ-009 The FSM SHALL have exactly three states, encoded as 2 bits: IDLE, GRANT and TURN.
- IDLE exits when REQ != 0 -> GRANT, with SEL = winner, EN = 1 and HOLD = 1.
- IDLE holds when REQ == 0, with EN = 0.
REQ-010 The winner SHALL be picked by round-robin: the first set REQ bit scanning upward from (LAST+1) mod 8, where LAST is the index of the most recent grant.
REQ-011 On entry to GRANT, LAST SHALL be set to the winner.
REQ-012 Grant latency SHALL be exactly one cycle: REQ is sampled high in IDLE at edge n, and EN/GNT are high after edge n.
- REQ-013 GRANT -> TURN, with EN = 0 on the next edge, when REQ[SEL] = 0 (voluntary release).
- REQ-014 GRANT -> TURN when HOLD == MAX_HOLD and any other REQ bit is set (preemption).
- REQ-015 GRANT stays in GRANT when HOLD == MAX_HOLD and no other requester is pending; HOLD saturates at MAX_HOLD.
- REQ-016 Otherwise GRANT stays in GRANT, and HOLD increments by 1 per cycle.
REQ-017 HOLD SHALL be a 4-bit counter that never wraps; values 0..MAX_HOLD only.
REQ-018 TURN SHALL last exactly one cycle with EN = 0, forming the bus turnaround gap.
- From TURN with REQ != 0 -> GRANT, with the winner chosen per REQ-010.
- From TURN with REQ == 0 -> IDLE.
REQ-019 A preempted owner that still holds REQ high SHALL re-compete normally in TURN; under round-robin it ranks last.
REQ-020 GNT SHALL have at most one bit set in any cycle.
REQ-021 GNT SHALL never be nonzero while EN = 0.
REQ-022 When REQ bits rise simultaneously, arbitration SHALL resolve them in one cycle without glitching GNT.
REQ-023 SEL SHALL hold its last value while EN = 0; consumers ignore SEL when EN = 0.
REQ-024 A REQ bit that drops in the same cycle as it is granted SHALL still receive a one-cycle grant, followed by TURN.

Reset
REQ-025 When RST is asserted, the module SHALL immediately apply, independent of CLK:
- state = IDLE
- EN = 0
- SEL = 3'b000
- GNT = 8'h00
- BUSY = 0
- HOLD = 0
- LAST = 3'b111, so that requester 0 has top priority after reset.
REQ-026 A reset asserted mid-grant SHALL drop GNT asynchronously.
REQ-027 After RST deasserts, the first arbitration SHALL occur at the first rising CLK edge at which REQ != 0.

Structure
REQ-028 The state encodings (IDLE/GRANT/TURN) and the HOLD width constant SHALL reside in the shared processor package.
REQ-029 GNT SHALL be produced by instantiating the existing 3-to-8 decoder sub-module (decoder8) driven by SEL and EN; GNT SHALL not be re-encoded locally.
REQ-030 The round-robin priority search SHALL be combinational logic inside bus_arbiter8; no further sub-modules are required.

Verification
REQ-031 Reset, then REQ=8'h01 from cycle 2 -> EN=1, SEL=0, GNT=8'h01 one cycle later; BUSY=1.
REQ-032 REQ=8'h81 simultaneously from IDLE after reset -> requester 0 is granted first; after REQ[0] drops: TURN for one cycle, then SEL=7, GNT=8'h80.
REQ-033 MAX_HOLD=4, REQ=8'h06 held constant -> requester 1 is granted for 4 cycles, then TURN, then requester 2 for 4 cycles, then TURN, then requester 1; no cycle has two GNT bits set.
REQ-034 MAX_HOLD=4, REQ=8'h08 alone for 20 cycles -> GNT=8'h08 continuously, HOLD stuck at 4, no TURN.
REQ-035 RST pulsed asynchronously (between CLK edges) during GRANT with GNT=8'h10 -> GNT=8'h00 and EN=0 before the next edge; after release, REQ=8'h10 -> grant to 4 again within one cycle.
REQ-036 Random REQ traffic for 10k cycles, with an assertion checker running throughout:
- GNT is one-hot or zero.
- GNT == decode(SEL) whenever EN = 1.
- Every TURN lasts exactly one cycle.
- Every continuously held request is granted within 8*(MAX_HOLD+1) cycles.

Source files
------------

// File: rtl/bus_arbiter8_pkg.sv
// Shared definitions for the 8-way round-robin bus arbiter.
//   state_e   : arbiter FSM state encoding (IDLE / GRANT / TURN)
//   HOLD_W    : width of the grant-hold counter
//   NUM_REQ   : number of requesters
//   SEL_W     : width of the owner index
package bus_arbiter8_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_TURN  = 2'd2
  } state_e;

  localparam int HOLD_W  = 4;
  localparam int NUM_REQ = 8;
  localparam int SEL_W   = 3;

endpackage

// File: rtl/bus_arbiter8_decoder8.sv
// 3-to-8 one-hot decoder with enable.
//   sel : input  [2:0] index to decode
//   en  : input        when low the output is all zeros
//   dec : output [7:0] one-hot decode of sel, gated by en
module decoder8
  import bus_arbiter8_pkg::*;
(
  input  logic [SEL_W-1:0]   sel,
  input  logic               en,
  output logic [NUM_REQ-1:0] dec
);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_dec
      assign dec[gi] = en && (sel == SEL_W'(gi));
    end
  endgenerate

endmodule

// File: rtl/bus_arbiter8.sv
// 8-requester round-robin bus arbiter with a bounded hold time and a
// one-cycle turnaround gap between owners.
//   CLK  : input        clock, rising edge
//   RST  : input        asynchronous active-high reset
//   REQ  : input  [7:0] per-requester request, held while the bus is wanted
//   SEL  : output [2:0] index of the current owner (registered)
//   EN   : output       grant valid (registered)
//   GNT  : output [7:0] one-hot grant, decode of SEL gated by EN
//   BUSY : output       high whenever the arbiter is not idle
module bus_arbiter8
  import bus_arbiter8_pkg::*;
#(
  parameter int MAX_HOLD = 15
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [NUM_REQ-1:0] REQ,
  output logic [SEL_W-1:0]   SEL,
  output logic               EN,
  output logic [NUM_REQ-1:0] GNT,
  output logic               BUSY
);

  localparam logic [HOLD_W-1:0] MAX_HOLD_L = HOLD_W'(MAX_HOLD);

  state_e            state_q, state_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic              en_q, en_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [SEL_W-1:0]  last_q, last_d;

  logic [SEL_W-1:0]   winner;
  logic [SEL_W-1:0]   scan_idx;
  logic               found;
  logic [NUM_REQ-1:0] owner_mask;
  logic               others_pending;

  // Round-robin search: first set request scanning upward from last_q+1.
  // The 3-bit index wraps naturally; the 8th probe lands back on last_q.
  always_comb begin
    winner   = last_q;
    found    = 1'b0;
    scan_idx = last_q;
    for (int k = 1; k <= NUM_REQ; k++) begin
      scan_idx = last_q + SEL_W'(k);
      if (!found && REQ[scan_idx]) begin
        winner = scan_idx;
        found  = 1'b1;
      end
    end
  end

  assign owner_mask     = NUM_REQ'(1) << sel_q;
  assign others_pending = |(REQ & ~owner_mask);

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    en_d    = en_q;
    hold_d  = hold_q;
    last_d  = last_q;
    case (state_q)
      // IDLE and TURN both arbitrate; they differ only in how they are entered.
      ST_IDLE, ST_TURN: begin
        if (|REQ) begin
          state_d = ST_GRANT;
          sel_d   = winner;
          en_d    = 1'b1;
          hold_d  = HOLD_W'(1);
          last_d  = winner;
        end else begin
          state_d = ST_IDLE;
          en_d    = 1'b0;
          hold_d  = '0;
        end
      end
      ST_GRANT: begin
        // Release on owner drop, or preempt once the hold budget is spent
        // and someone else is waiting.
        if (!REQ[sel_q] || (hold_q == MAX_HOLD_L && others_pending)) begin
          state_d = ST_TURN;
          en_d    = 1'b0;
          hold_d  = '0;
        end else if (hold_q != MAX_HOLD_L) begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        en_d    = 1'b0;
        hold_d  = '0;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= ST_IDLE;
      sel_q   <= '0;
      en_q    <= 1'b0;
      hold_q  <= '0;
      last_q  <= 3'b111;  // requester 0 wins first after reset
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      en_q    <= en_d;
      hold_q  <= hold_d;
      last_q  <= last_d;
    end
  end

  assign SEL  = sel_q;
  assign EN   = en_q;
  assign BUSY = (state_q != ST_IDLE);

  decoder8 u_decoder8 (
    .sel (sel_q),
    .en  (en_q),
    .dec (GNT)
  );

endmodule

// File: tb/tb_bus_arbiter8.sv
// Self-checking bench for bus_arbiter8 (MAX_HOLD = 4): directed scenarios
// plus randomized traffic compared against a behavioural model.
module tb_bus_arbiter8;

  localparam int MH    = 4;
  localparam int BOUND = 8 * (MH + 1);

  logic       CLK;
  logic       RST;
  logic [7:0] REQ;
  logic [2:0] SEL;
  logic       EN;
  logic [7:0] GNT;
  logic       BUSY;

  int n_checks;
  int n_pass;

  // Behavioural model: who owns the bus, whether a gap is running,
  // how long the owner has held it, and the round-robin pointer.
  int m_owner;
  int m_gap;
  int m_held;
  int m_last;
  int m_sel;

  bus_arbiter8 #(.MAX_HOLD(MH)) dut (
    .CLK  (CLK),
    .RST  (RST),
    .REQ  (REQ),
    .SEL  (SEL),
    .EN   (EN),
    .GNT  (GNT),
    .BUSY (BUSY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  function automatic int pick(input logic [7:0] r, input int last);
    for (int k = 1; k <= 8; k++) begin
      if (r[(last + k) % 8]) return (last + k) % 8;
    end
    return last;
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_gap   = 0;
    m_held  = 0;
    m_last  = 7;
    m_sel   = 0;
  endtask

  task automatic model_update(input logic [7:0] r);
    logic [7:0] others;
    if (m_owner >= 0) begin
      others = r & ~(8'(1) << m_owner);
      if (!r[m_owner] || (m_held >= MH && others != 0)) begin
        m_owner = -1;
        m_gap   = 1;
      end else if (m_held < MH) begin
        m_held = m_held + 1;
      end
    end else if (r != 0) begin
      m_owner = pick(r, m_last);
      m_sel   = m_owner;
      m_last  = m_owner;
      m_held  = 1;
      m_gap   = 0;
    end else begin
      m_gap = 0;
    end
  endtask

  function automatic logic [7:0] exp_gnt();
    return (m_owner >= 0) ? (8'(1) << m_owner) : 8'h00;
  endfunction

  // Drive REQ for one cycle; outputs are settled 1 time unit after the edge.
  task automatic step(input logic [7:0] r);
    REQ = r;
    @(posedge CLK);
    model_update(r);
    #1;
  endtask

  task automatic apply_reset();
    RST = 1'b1;
    REQ = 8'h00;
    @(posedge CLK);
    #1;
    RST = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    RST = 1'b0;
    REQ = 8'h00;
    @(posedge CLK);
    #2;
    RST = 1'b1;
    #1;
    n_checks++; if (EN !== 1'b0) $display("FAIL reset_en: got %b want 0", EN); else n_pass++;
    n_checks++; if (SEL !== 3'd0) $display("FAIL reset_sel: got %0d want 0", SEL); else n_pass++;
    n_checks++; if (GNT !== 8'h00) $display("FAIL reset_gnt: got %h want 00", GNT); else n_pass++;
    n_checks++; if (BUSY !== 1'b0) $display("FAIL reset_busy: got %b want 0", BUSY); else n_pass++;
    @(posedge CLK);
    #1;
    RST = 1'b0;
    model_reset();
    $display("test_reset done");
  endtask

  task automatic test_single();
    apply_reset();
    step(8'h00);
    n_checks++; if (BUSY !== 1'b0 || EN !== 1'b0) $display("FAIL single_idle: got busy=%b en=%b want 0 0", BUSY, EN); else n_pass++;
    step(8'h01);
    n_checks++; if (EN !== 1'b1) $display("FAIL single_en: got %b want 1", EN); else n_pass++;
    n_checks++; if (SEL !== 3'd0) $display("FAIL single_sel: got %0d want 0", SEL); else n_pass++;
    n_checks++; if (GNT !== 8'h01) $display("FAIL single_gnt: got %h want 01", GNT); else n_pass++;
    n_checks++; if (BUSY !== 1'b1) $display("FAIL single_busy: got %b want 1", BUSY); else n_pass++;
    // Request drops right after being granted: one-cycle grant then TURN.
    step(8'h00);
    n_checks++; if (EN !== 1'b0 || GNT !== 8'h00 || BUSY !== 1'b1) $display("FAIL single_turn: got en=%b gnt=%h busy=%b want 0 00 1", EN, GNT, BUSY); else n_pass++;
    step(8'h00);
    n_checks++; if (BUSY !== 1'b0 || SEL !== 3'd0) $display("FAIL single_back_idle: got busy=%b sel=%0d want 0 0", BUSY, SEL); else n_pass++;
    $display("test_single done");
  endtask

  task automatic test_simultaneous();
    apply_reset();
    step(8'h81);
    n_checks++; if (GNT !== 8'h01 || SEL !== 3'd0) $display("FAIL simul_first: got gnt=%h sel=%0d want 01 0", GNT, SEL); else n_pass++;
    step(8'h80);
    n_checks++; if (EN !== 1'b0 || GNT !== 8'h00 || BUSY !== 1'b1) $display("FAIL simul_turn: got en=%b gnt=%h busy=%b want 0 00 1", EN, GNT, BUSY); else n_pass++;
    n_checks++; if (SEL !== 3'd0) $display("FAIL simul_sel_hold: got %0d want 0", SEL); else n_pass++;
    step(8'h80);
    n_checks++; if (GNT !== 8'h80 || SEL !== 3'd7 || EN !== 1'b1) $display("FAIL simul_second: got gnt=%h sel=%0d en=%b want 80 7 1", GNT, SEL, EN); else n_pass++;
    step(8'h00);
    step(8'h00);
    $display("test_simultaneous done");
  endtask

  task automatic test_preempt();
    logic [7:0] exp_seq [11];
    exp_seq = '{8'h02, 8'h02, 8'h02, 8'h02, 8'h00,
                8'h04, 8'h04, 8'h04, 8'h04, 8'h00, 8'h02};
    apply_reset();
    for (int i = 0; i < 11; i++) begin
      step(8'h06);
      n_checks++;
      if (GNT !== exp_seq[i] || $countones(GNT) > 1)
        $display("FAIL preempt_cycle%0d: got gnt=%h want %h", i, GNT, exp_seq[i]);
      else n_pass++;
    end
    step(8'h00);
    step(8'h00);
    $display("test_preempt done");
  endtask

  task automatic test_saturate();
    int bad;
    apply_reset();
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      step(8'h08);
      if (GNT !== 8'h08 || EN !== 1'b1 || BUSY !== 1'b1) bad++;
    end
    n_checks++; if (bad != 0) $display("FAIL saturate_gnt: got %0d bad cycles want 0", bad); else n_pass++;
    n_checks++; if (dut.hold_q !== 4'd4) $display("FAIL saturate_hold: got %0d want 4", dut.hold_q); else n_pass++;
    step(8'h00);
    step(8'h00);
    $display("test_saturate done");
  endtask

  task automatic test_async_reset();
    apply_reset();
    step(8'h10);
    n_checks++; if (GNT !== 8'h10) $display("FAIL areset_pre: got %h want 10", GNT); else n_pass++;
    #3;
    RST = 1'b1;
    #1;
    n_checks++; if (GNT !== 8'h00 || EN !== 1'b0) $display("FAIL areset_drop: got gnt=%h en=%b want 00 0", GNT, EN); else n_pass++;
    #1;
    RST = 1'b0;
    model_reset();
    step(8'h10);
    n_checks++; if (GNT !== 8'h10 || SEL !== 3'd4) $display("FAIL areset_regrant: got gnt=%h sel=%0d want 10 4", GNT, SEL); else n_pass++;
    step(8'h00);
    step(8'h00);
    $display("test_async_reset done");
  endtask

  task automatic test_random();
    logic [7:0] cur;
    logic [7:0] eg;
    int waits [8];
    int max_wait;
    int turn_run;
    apply_reset();
    cur = 8'h00;
    turn_run = 0;
    for (int i = 0; i < 8; i++) waits[i] = 0;
    for (int c = 0; c < 10000; c++) begin
      for (int b = 0; b < 8; b++)
        if ($urandom_range(0, 9) == 0) cur[b] = ~cur[b];
      if ($urandom_range(0, 63) == 0) cur = 8'h00;
      step(cur);
      eg = exp_gnt();
      n_checks++;
      if (GNT !== eg || EN !== (m_owner >= 0) || SEL !== 3'(m_sel) || BUSY !== (m_owner >= 0 || m_gap != 0))
        $display("FAIL random_c%0d: got gnt=%h en=%b sel=%0d busy=%b want gnt=%h sel=%0d", c, GNT, EN, SEL, BUSY, eg, m_sel);
      else n_pass++;
      n_checks++;
      if ($countones(GNT) > 1 || (EN === 1'b1 && GNT !== (8'(1) << SEL)) || (EN === 1'b0 && GNT !== 8'h00))
        $display("FAIL random_onehot_c%0d: got gnt=%h sel=%0d en=%b", c, GNT, SEL, EN);
      else n_pass++;
      turn_run = (BUSY === 1'b1 && EN === 1'b0) ? turn_run + 1 : 0;
      n_checks++;
      if (turn_run > 1) $display("FAIL random_turn_c%0d: got gap of %0d cycles want 1", c, turn_run); else n_pass++;
      max_wait = 0;
      for (int b = 0; b < 8; b++) begin
        waits[b] = (cur[b] && !GNT[b]) ? waits[b] + 1 : 0;
        if (waits[b] > max_wait) max_wait = waits[b];
      end
      n_checks++;
      if (max_wait > BOUND) $display("FAIL random_starve_c%0d: got wait %0d want <= %0d", c, max_wait, BOUND); else n_pass++;
    end
    $display("test_random done");
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    RST = 1'b0;
    REQ = 8'h00;
    model_reset();
    test_reset();
    test_single();
    test_simultaneous();
    test_preempt();
    test_saturate();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
